// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   XLEN          : address / instruction word width
//   PC_STEP       : byte increment between sequential fetches
//   fetch_state_e : fetch control states (FETCH, FLUSH)
//   fetch_entry_t : one buffered fetch, PC plus instruction word
//   align_pc      : forces an address onto a word boundary
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int XLEN    = 32;
    localparam int PC_STEP = 4;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch_entry_t used both as the instruction buffer and as
// the PC tag queue for in-flight memory requests.
//   clock     : rising-edge clock
//   reset     : asynchronous active-low reset
//   clear     : drops all entries; wins over a same-cycle push or pop
//   push      : write push_data (ignored when full unless a pop frees the slot)
//   push_data : entry to store
//   pop       : remove the head entry (ignored when empty)
//   head      : oldest entry, all-zero while empty
//   count     : number of stored entries
//   empty     : no entries stored
//   full      : DEPTH entries stored
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign count = count_reg;

    assign do_pop  = pop & ~empty & ~clear;
    // A pop on a full FIFO frees the slot the write pointer is aiming at.
    assign do_push = push & (~full | do_pop) & ~clear;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries no reset; stale contents are hidden by the empty gate.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign head = empty ? '0 : mem[rd_ptr_reg];

endmodule

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch stage: owns the PC, issues word-aligned requests to instruction
// memory, buffers in-order responses with their PCs and hands them to decode.
// A redirect flushes buffered fetches and discards responses still in flight.
//   clock          : rising-edge clock
//   reset          : asynchronous active-low reset
//   imem_req_valid : fetch request valid
//   imem_req_ready : memory accepts the request
//   imem_req_addr  : word-aligned fetch address
//   imem_rsp_valid : response valid (in request order, no back-pressure)
//   imem_rsp_data  : instruction word
//   redirect_valid : single-cycle branch/jump redirect
//   redirect_pc    : redirect target (low two bits ignored)
//   inst_valid     : instruction available to decode
//   inst_ready     : decode consumes the instruction
//   inst_data      : instruction word
//   inst_pc        : PC of inst_data
// -----------------------------------------------------------------------------
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    fetch_state_e    state_reg;
    fetch_state_e    state_next;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_next;
    logic [CNT_W-1:0] outstanding_reg;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] drop_cnt_reg;
    logic [CNT_W-1:0] drop_cnt_next;

    fetch_entry_t     fifo_head;
    fetch_entry_t     fifo_push_data;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;

    fetch_entry_t     tag_head;
    fetch_entry_t     tag_push_data;
    logic [CNT_W-1:0] tag_count;
    logic             tag_empty;
    logic             tag_full;

    logic             inst_pop;
    logic             req_fire;
    logic             rsp_counted;
    logic             rsp_accept;
    logic [CNT_W:0]   credit_used;
    logic             unused_bits;

    // ------------------------------------------------------------------
    // Decode side
    // ------------------------------------------------------------------
    assign inst_valid = ~fifo_empty;
    assign inst_pop   = inst_valid & inst_ready;
    assign inst_data  = fifo_head.instr;
    assign inst_pc    = fifo_head.pc;

    // ------------------------------------------------------------------
    // Request side
    // Every in-flight request owns a buffer slot, so responses can never
    // be refused. A slot being popped this cycle already counts as free,
    // which is what lets a depth-2 buffer sustain one fetch per cycle.
    // ------------------------------------------------------------------
    assign credit_used = {1'b0, outstanding_reg} + {1'b0, fifo_count}
                       - (CNT_W+1)'(inst_pop);

    // The reset term keeps the request low for the whole reset window
    // while the state itself already sits in FETCH.
    assign imem_req_valid = reset
                          & (state_reg == FETCH)
                          & (credit_used < (CNT_W+1)'(FIFO_DEPTH))
                          & ~redirect_valid;
    assign imem_req_addr  = align_pc(pc_reg);
    assign req_fire       = imem_req_valid & imem_req_ready;

    // ------------------------------------------------------------------
    // Response side
    // A response retires an outstanding request in either state; it is
    // only buffered in FETCH and only when no redirect overrides it.
    // ------------------------------------------------------------------
    assign rsp_counted = imem_rsp_valid & (outstanding_reg != '0);
    assign rsp_accept  = rsp_counted & (state_reg == FETCH)
                       & ~redirect_valid & ~tag_empty;

    assign fifo_push_data = '{pc: tag_head.pc, instr: imem_rsp_data};
    assign tag_push_data  = '{pc: imem_req_addr, instr: '0};

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        drop_cnt_next    = drop_cnt_reg;
        outstanding_next = outstanding_reg + CNT_W'(req_fire) - CNT_W'(rsp_counted);

        if (redirect_valid) begin
            pc_next = align_pc(redirect_pc);
        end else if (req_fire) begin
            pc_next = pc_reg + XLEN'(PC_STEP);
        end

        case (state_reg)
            FETCH: begin
                if (redirect_valid) begin
                    // A response arriving with the redirect is already one
                    // of the dropped ones, so it is not waited for again.
                    drop_cnt_next = outstanding_reg - CNT_W'(rsp_counted);
                    if (drop_cnt_next != '0) begin
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // A further redirect here only retargets the PC.
                if (rsp_counted) begin
                    drop_cnt_next = drop_cnt_reg - CNT_W'(1);
                end
                if (drop_cnt_next == '0) begin
                    state_next = FETCH;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= FETCH;
            pc_reg          <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Buffers
    // ------------------------------------------------------------------
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (rsp_accept),
        .push_data (fifo_push_data),
        .pop       (inst_pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // PC tags of in-flight requests; its depth matches the credit limit.
    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clock     (clock),
        .reset     (reset),
        .clear     (redirect_valid),
        .push      (req_fire),
        .push_data (tag_push_data),
        .pop       (rsp_accept),
        .head      (tag_head),
        .count     (tag_count),
        .empty     (tag_empty),
        .full      (tag_full)
    );

    // Status bits and fields that this stage has no use for.
    assign unused_bits = ^{tag_head.instr, tag_count, tag_full, fifo_full,
                           redirect_pc[1:0]};

endmodule
